// File: rtl/aes_pkg.sv
// Shared types, round constants and byte-level helpers for the AES-128 inverse cipher.
// Byte 0 of a block sits in bits 127:120, and a column is four consecutive bytes.
package aes_pkg;

  typedef logic [127:0] block_t;
  typedef logic [31:0]  word_t;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r moves right by r columns.
  function automatic block_t inv_shift_rows(input block_t s);
    block_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic word_t inv_mix_column(input word_t w);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = w[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless bypass_mix is set (last round).
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         bypass_mix,
  output logic [127:0] state_o
);

  block_t shifted, subbed, keyed, mixed;

  assign shifted = inv_shift_rows(state_i);

  for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
    bSbox u_sbox (
      .a       (shifted[127-8*gi -: 8]),
      .encrypt (1'b0),
      .q       (subbed[127-8*gi -: 8])
    );
  end

  assign keyed = subbed ^ rk_i;

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    assign mixed[127-32*gi -: 32] = inv_mix_column(keyed[127-32*gi -: 32]);
  end

  assign state_o = bypass_mix ? keyed : mixed;

endmodule

// File: rtl/bSbox.sv
// Combined forward/inverse AES S-box: GF(2^8) inversion shared by both directions,
// with the affine transform applied after (encrypt=1) or its inverse before (encrypt=0).
module bSbox (
  input  logic [7:0] a,
  input  logic       encrypt,
  output logic [7:0] q
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  logic [7:0] inv_in, x2, x3, x12, x15, x240, inv_out;

  assign inv_in = encrypt ? a : (rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);

  // Inverse as x^254 (0 maps to 0 for free).
  assign x2      = gf_mul(inv_in, inv_in);
  assign x3      = gf_mul(x2, inv_in);
  assign x12     = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
  assign x15     = gf_mul(x12, x3);
  assign x240    = gf_mul(gf_mul(gf_mul(gf_mul(x15, x15), gf_mul(x15, x15)),
                                 gf_mul(gf_mul(x15, x15), gf_mul(x15, x15))),
                          gf_mul(gf_mul(gf_mul(x15, x15), gf_mul(x15, x15)),
                                 gf_mul(gf_mul(x15, x15), gf_mul(x15, x15))));
  assign inv_out = gf_mul(gf_mul(x240, x12), x2);

  assign q = encrypt ? (inv_out ^ rotl(inv_out, 1) ^ rotl(inv_out, 2) ^ rotl(inv_out, 3)
                        ^ rotl(inv_out, 4) ^ 8'h63)
                     : inv_out;

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption, one round per clock, starting from the round-10 key
// and walking the key schedule backwards on the fly.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter bit CLR_PT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         clr,
  input  logic [127:0] ct,
  input  logic [127:0] key,
  output logic [127:0] pt,
  output logic         busy,
  output logic         done
);

  fsm_t       fsm_q, fsm_d;
  block_t     state_q, state_d, rk_q, rk_d, pt_q, pt_d;
  logic [3:0] rnd_q, rnd_d;
  logic       busy_q, busy_d, done_q, done_d;

  word_t      w0, w1, w2, w3, n0, n1, n2, n3, rot_w, sub_w;
  logic [7:0] rc;
  block_t     rk_step, round_out;

  // Undo one forward key-expansion step; rcon of the key being undone is rnd+1.
  assign {w0, w1, w2, w3} = rk_q;
  assign n3    = w3 ^ w2;
  assign n2    = w2 ^ w1;
  assign n1    = w1 ^ w0;
  assign rot_w = {n3[23:0], n3[31:24]};
  assign rc    = RCON[rnd_q + 4'd1];

  for (genvar gi = 0; gi < 4; gi++) begin : g_key_sbox
    bSbox u_key_sbox (
      .a       (rot_w[31-8*gi -: 8]),
      .encrypt (1'b1),
      .q       (sub_w[31-8*gi -: 8])
    );
  end

  assign n0      = w0 ^ sub_w ^ {rc, 24'h0};
  assign rk_step = {n0, n1, n2, n3};

  aes_inv_round u_round (
    .state_i    (state_q),
    .rk_i       (rk_step),
    .bypass_mix (fsm_q == FINAL),
    .state_o    (round_out)
  );

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    pt_d    = pt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (clr) begin
      fsm_d   = IDLE;
      state_d = '0;
      rk_d    = '0;
      rnd_d   = '0;
      busy_d  = 1'b0;
      if (CLR_PT) pt_d = '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (start) begin
            state_d = ct ^ key;
            rk_d    = key;
            rnd_d   = 4'd9;
            busy_d  = 1'b1;
            fsm_d   = ROUND;
          end
        end
        ROUND: begin
          state_d = round_out;
          rk_d    = rk_step;
          rnd_d   = rnd_q - 4'd1;
          if (rnd_q == 4'd1) fsm_d = FINAL;
        end
        FINAL: begin
          pt_d   = round_out;
          done_d = 1'b1;
          busy_d = 1'b0;
          fsm_d  = IDLE;
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
      pt_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
      pt_q    <= pt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pt   = pt_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed FIPS-197 vectors, multi-cycle corner cases, and random blocks checked
// against an independent forward-AES model.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         clr = 1'b0;
  logic [127:0] ct = '0;
  logic [127:0] key = '0;
  logic [127:0] pt;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  aes_inv_cipher_iter #(.CLR_PT(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .clr   (clr),
    .ct    (ct),
    .key   (key),
    .pt    (pt),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  localparam logic [127:0] C1_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sbox_t[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic aes_enc(input logic [127:0] k, input logic [127:0] p,
                         output logic [127:0] c, output logic [127:0] rk10);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [7:0]  s [16];
    logic [7:0]  u [16];
    logic [7:0]  a [4];
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) u[i] = sbox_t[s[i]];
      for (int cc = 0; cc < 4; cc++)
        for (int rr = 0; rr < 4; rr++) s[rr+4*cc] = u[rr+4*((cc+rr)%4)];
      if (r < 10) begin
        for (int cc = 0; cc < 4; cc++) begin
          for (int rr = 0; rr < 4; rr++) a[rr] = s[4*cc+rr];
          for (int rr = 0; rr < 4; rr++)
            s[4*cc+rr] = gmul(a[rr], 8'h02) ^ gmul(a[(rr+1)%4], 8'h03) ^ a[(rr+2)%4] ^ a[(rr+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
    end
    c = '0;
    for (int i = 0; i < 16; i++) c[127-8*i -: 8] = s[i];
    rk10 = {w[40], w[41], w[42], w[43]};
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Leaves the bench at the falling edge just after the accepting edge.
  task automatic do_start(input logic [127:0] k, input logic [127:0] c);
    @(negedge clk);
    key   = k;
    ct    = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat counts falling edges from the one where start was driven.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 1;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  vec_t         vecs [2];
  int           lat, bcnt, dcnt, didx;
  logic [127:0] got, m_ct, m_rk, r_pt, r_key;

  initial begin
    vecs[0] = '{"fips_c1",   C1_KEY, C1_CT, C1_PT};
    vecs[1] = '{"fips_appb", B_KEY,  B_CT,  B_PT};

    build_sbox();
    aes_enc(128'h000102030405060708090a0b0c0d0e0f, C1_PT, m_ct, m_rk);
    chk("model_ct", m_ct, C1_CT);
    chk("model_rk10", m_rk, C1_KEY);

    repeat (3) @(negedge clk);
    chk("reset_pt", pt, '0);
    chk("reset_busy", 128'(busy), '0);
    chk("reset_done", 128'(done), '0);
    rst_n = 1'b1;
    count_dones(5, dcnt);
    chk("idle_no_done", 128'(dcnt), 128'd0);

    for (int i = 0; i < 2; i++) begin
      do_start(vecs[i].key, vecs[i].ct);
      wait_done(lat, bcnt);
      chk({vecs[i].name, "_pt"}, pt, vecs[i].pt);
      chk({vecs[i].name, "_latency"}, 128'(lat), 128'd11);
      chk({vecs[i].name, "_busy_cycles"}, 128'(bcnt), 128'd10);
      @(negedge clk);
      chk({vecs[i].name, "_done_pulse"}, 128'(done), '0);
      $display("txn %s pt=%h latency=%0d busy=%0d", vecs[i].name, pt, lat, bcnt);
    end

    do_start(C1_KEY, C1_CT);
    wait_done(lat, bcnt);
    chk("b2b_first_pt", pt, C1_PT);
    key   = B_KEY;
    ct    = B_CT;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_after_accept", 128'(busy), 128'd1);
    wait_done(lat, bcnt);
    chk("b2b_second_latency", 128'(lat), 128'd11);
    chk("b2b_second_pt", pt, B_PT);
    $display("txn back_to_back pt=%h latency=%0d", pt, lat);

    do_start(C1_KEY, C1_CT);
    key  = B_KEY;
    ct   = B_CT;
    dcnt = 0;
    didx = 0;
    got  = '0;
    for (int idx = 1; idx <= 16; idx++) begin
      if (done) begin
        dcnt++;
        didx = idx;
        got  = pt;
      end
      start = (idx == 3 || idx == 7);
      @(negedge clk);
    end
    start = 1'b0;
    chk("ignored_start_done_count", 128'(dcnt), 128'd1);
    chk("ignored_start_done_index", 128'(didx), 128'd11);
    chk("ignored_start_pt", got, C1_PT);
    $display("txn ignored_start dones=%0d pt=%h", dcnt, got);

    do_start(C1_KEY, C1_CT);
    repeat (4) @(negedge clk);
    clr   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clr   = 1'b0;
    start = 1'b0;
    chk("clr_busy", 128'(busy), '0);
    chk("clr_pt", pt, '0);
    chk("clr_done", 128'(done), '0);
    count_dones(15, dcnt);
    chk("clr_no_done", 128'(dcnt), 128'd0);
    do_start(B_KEY, B_CT);
    wait_done(lat, bcnt);
    chk("after_clr_pt", pt, B_PT);
    chk("after_clr_latency", 128'(lat), 128'd11);
    $display("txn clr_then_start pt=%h latency=%0d", pt, lat);

    do_start(C1_KEY, C1_CT);
    repeat (3) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pt", pt, '0);
    chk("async_rst_busy", 128'(busy), '0);
    chk("async_rst_done", 128'(done), '0);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(15, dcnt);
    chk("async_rst_no_done", 128'(dcnt), 128'd0);
    $display("txn async_reset dones_after=%0d", dcnt);

    for (int n = 0; n < 1000; n++) begin
      r_pt  = {$urandom, $urandom, $urandom, $urandom};
      r_key = {$urandom, $urandom, $urandom, $urandom};
      aes_enc(r_key, r_pt, m_ct, m_rk);
      do_start(m_rk, m_ct);
      wait_done(lat, bcnt);
      chk($sformatf("rand%0d_pt", n), pt, r_pt);
      $display("txn rand %0d pt=%h", n, pt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
- Iterative AES-128 decryption core (FIPS-197 inverse cipher): one round per clock.
- Datapath: 16 bSbox instances with encrypt=0 for InvSubBytes. The key path runs the inverse key schedule on the fly using 4 bSbox instances with encrypt=1.
- Sits beside the tiny_AES encryption datapath as its decrypt counterpart.
- Takes the round-10 key directly, so no key pre-expansion pass is needed.

Parameters:
- CLR_PT, 1, when 1 the pt output is zeroed on clr; when 0 pt holds its last value.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- clr  in  1  synchronous abort; returns to IDLE, takes priority over start.
- ct  in  128  ciphertext; bit 127 = byte 0 (FIPS-197 order).
- key  in  128  round-10 key rk10, same byte order; sampled with start.
- pt  out  128  plaintext; valid from done until the next accepted start.
- busy  out  1  high from the cycle after start is accepted through the final round.
- done  out  1  one-cycle pulse when pt is valid.

Behaviour:
- Reset (rst_n=0, async): FSM=IDLE, state/rk/round counter=0, pt=0, busy=0, done=0.
- FSM states: IDLE, ROUND, FINAL.
- IDLE, start=1 at edge E0:
  - state <= ct ^ key; rk <= key; rnd <= 9; FSM -> ROUND; busy <= 1.
- ROUND, edges E1..E9, r = rnd:
  - rk_r = invexp(rk, rcon[r+1]).
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_r).
  - rk <= rk_r; rnd <= rnd-1.
  - At r=1 the FSM goes to FINAL.
- FINAL, edge E10:
  - rk_0 = invexp(rk, 0x01).
  - pt <= InvSubBytes(InvShiftRows(state)) ^ rk_0.
  - done <= 1; busy <= 0; FSM -> IDLE.
- Latency: start sampled at E0; done=1 in the cycle after E10. Throughput is 11 cycles per block.
- invexp(k, rc), words w0..w3 (w0 = bits 127:96):
  - w3' = w3^w2; w2' = w2^w1; w1' = w1^w0.
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {rc,24'h0}.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, held in a ROM indexed by rnd+1.
- InvMixColumns: per column, multiply by {0e,0b,0d,09} in GF(2^8) mod x^8+x^4+x^3+x+1. Implemented with xtime chains, no multiplier.
- Boundaries:
  - start while busy=1: ignored, no queuing.
  - start in the same cycle done=1: FSM is IDLE, so it is accepted. Back-to-back blocks give one done per 11 cycles.
  - clr=1 in any state: FSM -> IDLE, busy=0, done=0, state/rk zeroed. pt zeroed iff CLR_PT=1. Any start in the same cycle is dropped.
  - rst_n asserted mid-operation: immediate async return to reset values; no done is produced.
  - ct/key may change after acceptance without effect.
  - done is never asserted without a preceding accepted start.
- Sbox timing: the bSbox path is combinational, and one full round plus one key step must close in a single clock. No multicycle path.

Decomposition:
- Package aes_pkg holds:
  - the 128-bit block type and the 32-bit word type;
  - the RCON[1:10] constant array;
  - FSM state enum {IDLE, ROUND, FINAL};
  - functions xtime, inv_shift_rows, inv_mix_column.
- Natural sub-module: aes_inv_round. It is combinational and contains:
  - InvShiftRows;
  - 16× bSbox with encrypt=1'b0;
  - AddRoundKey;
  - optional InvMixColumns, selected by a bypass_mix input.
- The top level holds the FSM, the registers, and the key-step logic (4× bSbox with encrypt=1'b1).

Test Plan:
- FIPS-197 C.1:
  - inputs: key=13111d7fe3944a17f307a78b4d2b30c5, ct=69c4e0d86a7b0430d8cdb78070b4c55a;
  - required: pt=00112233445566778899aabbccddeeff, done exactly 11 cycles after start, busy high for 10 cycles.
- FIPS-197 App.B:
  - inputs: key=d014f9a8c9ee2589e13f0cc8b6630ca6, ct=3925841d02dc09fbdc118597196a0b32;
  - required: pt=3243f6a8885a308d313198a2e0370734.
- Back-to-back:
  - stimulus: C.1 vector, then App.B with start asserted in the done cycle;
  - required: second done 11 cycles after the first, correct pts.
- start pulsed at cycles 3 and 7 of an operation -> ignored; a single done with the C.1 pt.
- clr at cycle 5 with CLR_PT=1 -> busy=0 next cycle, pt=0, no done; a new start then completes correctly.
- rst_n low mid-run (async, off clock edge):
  - required: all outputs 0 immediately, no spurious done after release.
  - stimulus after release: random key/ct pairs checked against a software AES model (1000 vectors) -> all pt match.
